// File: rtl/spi_master_ctrl.sv
// SPI master transaction sequencer: walks one descriptor through the CMD, ADDR,
// DUMMY, WRITE and READ phases, programming the tx/rx shifters and gating clock/CS.
module spi_master_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_cmd,
    input  logic [5:0]       cfg_cmd_len,
    input  logic [31:0]      cfg_addr,
    input  logic [5:0]       cfg_addr_len,
    input  logic [CNT_W-1:0] cfg_dummy,
    input  logic [CNT_W-1:0] cfg_wr_len,
    input  logic [CNT_W-1:0] cfg_rd_len,
    input  logic             cfg_quad,
    input  logic             abort,
    input  logic             spi_edge,
    output logic             spi_clk_en,
    output logic             spi_csn,
    output logic             busy,
    output logic             eot,
    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic             tx_en,
    output logic             tx_quad,
    output logic [CNT_W-1:0] tx_counter,
    output logic             tx_counter_upd,
    output logic [31:0]      tx_data,
    output logic             tx_data_valid,
    input  logic             tx_data_ready,
    input  logic             tx_done,
    output logic             rx_en,
    output logic [CNT_W-1:0] rx_counter,
    output logic             rx_counter_upd,
    input  logic             rx_done
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, WRITE, READ, EOT} state_e;

    typedef struct packed {
        logic [31:0]      cmd;
        logic [5:0]       cmd_len;
        logic [31:0]      addr;
        logic [5:0]       addr_len;
        logic [CNT_W-1:0] dummy;
        logic [CNT_W-1:0] wr_len;
        logic [CNT_W-1:0] rd_len;
        logic             quad;
    } desc_t;

    state_e           state_q, state_d;
    desc_t            desc_q, desc_d, cfg_desc;
    logic             cfg_ready_q, cfg_ready_d;
    logic             busy_q, busy_d;
    logic             csn_q, csn_d;
    logic             clk_en_q, clk_en_d;
    logic             eot_q, eot_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_quad_q, tx_quad_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             tx_upd_q, tx_upd_d;
    logic [31:0]      tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             rx_en_q, rx_en_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             rx_upd_q, rx_upd_d;
    logic [CNT_W-1:0] dummy_cnt_q, dummy_cnt_d;
    logic             accept;
    logic             in_phase;
    logic             in_write;

    // First phase after 'cur' whose length is nonzero; EOT when none remain.
    function automatic state_e next_phase(input state_e cur, input desc_t d);
        state_e nxt;
        nxt = EOT;
        if (d.rd_len   != '0 && cur < READ)  nxt = READ;
        if (d.wr_len   != '0 && cur < WRITE) nxt = WRITE;
        if (d.dummy    != '0 && cur < DUMMY) nxt = DUMMY;
        if (d.addr_len != '0 && cur < ADDR)  nxt = ADDR;
        if (d.cmd_len  != '0 && cur < CMD)   nxt = CMD;
        return nxt;
    endfunction

    assign cfg_desc = '{cmd: cfg_cmd, cmd_len: cfg_cmd_len, addr: cfg_addr,
                        addr_len: cfg_addr_len, dummy: cfg_dummy, wr_len: cfg_wr_len,
                        rd_len: cfg_rd_len, quad: cfg_quad};

    assign accept   = (state_q == IDLE) && cfg_ready_q && cfg_valid;
    assign in_phase = state_q inside {CMD, ADDR, DUMMY, WRITE, READ};
    assign in_write = (state_q == WRITE);

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        desc_d      = desc_q;
        csn_d       = csn_q;
        clk_en_d    = clk_en_q;
        eot_d       = 1'b0;
        tx_en_d     = tx_en_q;
        tx_quad_d   = tx_quad_q;
        tx_cnt_d    = tx_cnt_q;
        tx_upd_d    = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        rx_en_d     = rx_en_q;
        rx_cnt_d    = rx_cnt_q;
        rx_upd_d    = 1'b0;
        dummy_cnt_d = dummy_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    desc_d  = cfg_desc;
                    csn_d   = 1'b0;
                    state_d = next_phase(IDLE, cfg_desc);
                end
            end
            CMD, ADDR, WRITE: begin
                if (state_q != WRITE && tx_valid_q && tx_data_ready) tx_valid_d = 1'b0;
                // A done coinciding with the counter load belongs to the previous phase.
                if (tx_done && !tx_upd_q) state_d = next_phase(state_q, desc_q);
            end
            DUMMY: begin
                if (spi_edge) begin
                    dummy_cnt_d = dummy_cnt_q - 1'b1;
                    if (dummy_cnt_q <= CNT_W'(1)) state_d = next_phase(DUMMY, desc_q);
                end
            end
            READ: begin
                if (rx_done && !rx_upd_q) state_d = next_phase(READ, desc_q);
            end
            EOT: begin
                if (!eot_q) begin
                    csn_d = 1'b1;
                    eot_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_phase && abort) state_d = EOT;

        // Phase entry programs the shifters for the state being entered.
        if (state_d != state_q) begin
            unique case (state_d)
                CMD, ADDR: begin
                    clk_en_d   = 1'b1;
                    tx_en_d    = 1'b1;
                    rx_en_d    = 1'b0;
                    tx_upd_d   = 1'b1;
                    tx_valid_d = 1'b1;
                    if (state_d == CMD) begin
                        tx_quad_d = 1'b0;
                        tx_cnt_d  = CNT_W'(desc_d.cmd_len);
                        tx_data_d = desc_d.cmd << (6'd32 - desc_d.cmd_len);
                    end else begin
                        tx_quad_d = desc_d.quad;
                        tx_cnt_d  = CNT_W'(desc_d.addr_len);
                        tx_data_d = desc_d.addr << (6'd32 - desc_d.addr_len);
                    end
                end
                DUMMY: begin
                    clk_en_d    = 1'b1;
                    tx_en_d     = 1'b0;
                    rx_en_d     = 1'b0;
                    tx_valid_d  = 1'b0;
                    dummy_cnt_d = desc_d.dummy;
                end
                WRITE: begin
                    clk_en_d   = 1'b1;
                    tx_en_d    = 1'b1;
                    rx_en_d    = 1'b0;
                    tx_quad_d  = desc_d.quad;
                    tx_cnt_d   = desc_d.wr_len;
                    tx_upd_d   = 1'b1;
                    tx_valid_d = 1'b0;
                end
                READ: begin
                    clk_en_d   = 1'b1;
                    tx_en_d    = 1'b0;
                    rx_en_d    = 1'b1;
                    tx_quad_d  = 1'b0;
                    tx_valid_d = 1'b0;
                    rx_cnt_d   = desc_d.rd_len;
                    rx_upd_d   = 1'b1;
                end
                EOT: begin
                    clk_en_d   = 1'b0;
                    tx_en_d    = 1'b0;
                    rx_en_d    = 1'b0;
                    tx_quad_d  = 1'b0;
                    tx_valid_d = 1'b0;
                end
                default: ;
            endcase
        end

        busy_d      = (state_d != IDLE);
        cfg_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            desc_q      <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            csn_q       <= 1'b1;
            clk_en_q    <= 1'b0;
            eot_q       <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_quad_q   <= 1'b0;
            tx_cnt_q    <= '0;
            tx_upd_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            rx_en_q     <= 1'b0;
            rx_cnt_q    <= '0;
            rx_upd_q    <= 1'b0;
            dummy_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            desc_q      <= desc_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            csn_q       <= csn_d;
            clk_en_q    <= clk_en_d;
            eot_q       <= eot_d;
            tx_en_q     <= tx_en_d;
            tx_quad_q   <= tx_quad_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_upd_q    <= tx_upd_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            rx_en_q     <= rx_en_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_upd_q    <= rx_upd_d;
            dummy_cnt_q <= dummy_cnt_d;
        end
    end

    // WRITE streams FIFO words straight into the shifter; the pop only fires on real data.
    assign tx_data        = in_write ? wr_data : tx_data_q;
    assign tx_data_valid  = in_write ? (wr_valid && !abort) : tx_valid_q;
    assign wr_ready       = in_write && tx_data_ready && wr_valid && !abort;
    assign cfg_ready      = cfg_ready_q;
    assign busy           = busy_q;
    assign spi_csn        = csn_q;
    assign spi_clk_en     = clk_en_q;
    assign eot            = eot_q;
    assign tx_en          = tx_en_q;
    assign tx_quad        = tx_quad_q;
    assign tx_counter     = tx_cnt_q;
    assign tx_counter_upd = tx_upd_q;
    assign rx_en          = rx_en_q;
    assign rx_counter     = rx_cnt_q;
    assign rx_counter_upd = rx_upd_q;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Transaction sequencer for the SPI master datapath. Accepts one transaction descriptor per handshake and walks it through command, address, dummy, write and read phases. For each phase it programs the tx/rx shifters (bit counts, quad mode, enables), muxes command/address words or FIFO write data into the tx shifter, and gates the SPI clock generator and chip select. It sits between the register/AXI front end and the spi_master_tx / rx shifters.

Parameters:
CNT_W, 16, width of bit-count and dummy-count fields; matches the shifter counter width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  descriptor valid
cfg_ready  out  1  descriptor accepted; high only in IDLE
cfg_cmd  in  32  command bits, right-aligned
cfg_cmd_len  in  6  command length in bits, 0..32; 0 skips the phase
cfg_addr  in  32  address bits, right-aligned
cfg_addr_len  in  6  address length in bits, 0..32; 0 skips the phase
cfg_dummy  in  CNT_W  dummy clock edges; 0 skips the phase
cfg_wr_len  in  CNT_W  write data length in bits; 0 skips the phase
cfg_rd_len  in  CNT_W  read data length in bits; 0 skips the phase
cfg_quad  in  1  quad mode for the addr, write and read phases
abort  in  1  terminate the current transaction
spi_edge  in  1  tx shift strobe from the clock generator
spi_clk_en  out  1  enables the SPI clock generator
spi_csn  out  1  chip select, active low
busy  out  1  high while state is not IDLE
eot  out  1  one-cycle end-of-transaction pulse
wr_data  in  32  write FIFO data
wr_valid  in  1  write FIFO data valid
wr_ready  out  1  write FIFO pop
tx_en  out  1  tx shifter enable
tx_quad  out  1  tx shifter quad mode
tx_counter  out  CNT_W  tx bit count
tx_counter_upd  out  1  load tx bit count (one-cycle pulse)
tx_data  out  32  tx shifter data
tx_data_valid  out  1  tx data valid
tx_data_ready  in  1  tx data accepted
tx_done  in  1  tx phase complete
rx_en  out  1  rx shifter enable
rx_counter  out  CNT_W  rx bit count
rx_counter_upd  out  1  load rx bit count (one-cycle pulse)
rx_done  in  1  rx phase complete

Behaviour:
- States: IDLE, CMD, ADDR, DUMMY, WRITE, READ, EOT. All outputs are registered.
- Reset (synchronous, takes priority in any state, mid-transaction included): state IDLE, spi_csn=1, every other output 0, descriptor registers cleared.
- IDLE: cfg_ready=1. When cfg_valid=1, latch the whole descriptor, drive spi_csn=0, and go to the first phase with nonzero length in the order CMD, ADDR, DUMMY, WRITE, READ. If every length is 0, go straight to EOT.
- Phase entry (all phases except DUMMY): drive counter_upd for exactly 1 cycle, with counter = the phase length in bits. spi_clk_en=1 from the entry cycle until EOT.
- CMD phase:
  - tx_quad=0 always.
  - tx_data = cfg_cmd << (32 - cmd_len), so the MSB is at bit 31.
  - tx_data_valid is raised in the entry cycle and held until tx_data_ready.
- ADDR phase: same as CMD, using cfg_addr/addr_len, with tx_quad=cfg_quad.
- DUMMY phase:
  - Internal down-counter loaded with cfg_dummy, decremented on each spi_edge.
  - tx_en=0 and rx_en=0.
  - Phase ends in the cycle the counter reaches 0.
- WRITE phase:
  - tx_data = wr_data, tx_data_valid = wr_valid, wr_ready = tx_data_ready.
  - Combinational passthrough within the phase, so FIFO words refill at the shifter's 32-bit (or 8-nibble quad) boundaries.
  - tx_quad=cfg_quad.
- tx_en=1 throughout the CMD, ADDR and WRITE phases. Each of these phases ends on tx_done.
- READ phase: rx_en=1, rx_counter=rd_len, rx_counter_upd pulse on entry. The phase ends on rx_done.
- Phase exit: the next state is the next nonzero phase, or EOT. Entering the next phase takes 1 cycle after done, with no idle SPI cycles inserted. A done arriving in the same cycle as counter_upd is ignored.
- Quad-mode lengths: passed unchanged; the shifter divides by 4. Lengths that are not multiples of 4 are a software error with undefined data, but the FSM still terminates.
- EOT:
  - Cycle 1: spi_clk_en=0, tx_en=0, rx_en=0.
  - Cycle 2: spi_csn=1, eot=1, then IDLE.
  - Back-to-back descriptors therefore have at least 1 cycle of CS high.
- abort in any non-IDLE state: drop tx/rx enables and valids in the next cycle and go to EOT. wr_ready is never asserted after abort. abort in IDLE is ignored.
- cfg_valid outside IDLE is ignored (cfg_ready=0).

Test Plan:
- cmd=0x9F, len 8; rd_len=24; others 0 -> tx_counter=8 with tx_data=0x9F000000 and tx_quad=0; then rx_counter=24; eot pulses 2 cycles after rx_done, csn high.
- cmd 0xEB/8, addr 0x123456/24, quad=1, dummy=6, rd_len=64 -> ADDR tx_data=0x12345600 with tx_quad=1; exactly 6 spi_edge counted before rx_counter_upd; state order CMD, ADDR, DUMMY, READ.
- cmd 0x02/8, wr_len=96, FIFO holds 3 words -> exactly 3 wr_ready pulses; wr_valid dropped mid-phase stalls pop without a state change; EOT follows tx_done.
- All lengths 0, cfg_valid -> csn low 1 cycle, then EOT; eot=1 and no counter_upd at all.
- abort during WRITE after 1 word -> tx_en=0 next cycle; csn=1 and eot 2 cycles later; no further wr_ready.
- rst asserted mid-READ -> next cycle IDLE, csn=1, busy=0, spi_clk_en=0; new descriptor accepted normally.
